// File: rtl/cache_data_bank.sv
// L1 data-cache data array: line storage with byte-enabled CPU stores through a 1-entry store buffer,
// beat-serial refill from the bus side, and an optional read bypass of in-flight writes.
module cache_data_bank #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned LINE_WORDS    = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          ENABLE_BYPASS = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  rd_req,
    input  logic [ADDR_WIDTH-1:0]                 rd_addr,
    output logic                                  rd_valid,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [DATA_WIDTH*LINE_WORDS-1:0]      rd_line,
    input  logic                                  st_req,
    output logic                                  st_ready,
    input  logic [ADDR_WIDTH-1:0]                 st_addr,
    input  logic [DATA_WIDTH-1:0]                 st_wdata,
    input  logic [DATA_WIDTH/8-1:0]               st_be,
    input  logic                                  rf_start,
    input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] rf_index,
    input  logic                                  rf_valid,
    output logic                                  rf_ready,
    input  logic [DATA_WIDTH-1:0]                 rf_data,
    input  logic                                  rf_last,
    output logic                                  rf_done,
    output logic                                  busy
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned BE_W    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned LINE_W  = DATA_WIDTH * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [OFF_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [INDEX_W-1:0]     rf_index_q, rf_index_d;
    logic                   sb_valid_q, sb_valid_d;
    logic [ADDR_WIDTH-1:0]  sb_addr_q, sb_addr_d;
    logic [DATA_WIDTH-1:0]  sb_data_q, sb_data_d;
    logic [BE_W-1:0]        sb_be_q, sb_be_d;
    logic                   rd_valid_q;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [LINE_W-1:0]      rd_line_q, line_flat;
    logic                   rf_ready_q, rf_done_q, busy_q;

    logic                   beat_acc, drain_now, st_acc;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [BE_W-1:0]        wr_be;
    logic [INDEX_W-1:0]     rd_idx;
    logic [DATA_WIDTH-1:0]  line_w [LINE_WORDS];
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Refill sequencing: IDLE -> FILL (beats) -> DONE (one-cycle pulse) -> IDLE
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rf_index_d = rf_index_q;
        beat_acc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rf_start) begin
                    state_d    = S_FILL;
                    rf_index_d = rf_index;
                    beat_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (rf_valid) begin
                    beat_acc   = 1'b1;
                    beat_cnt_d = beat_cnt_q + OFF_W'(1);
                    if (rf_last || beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        state_d    = S_DONE;
                        beat_cnt_d = '0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A buffered store to the line under refill is held back so it lands on top of the refilled data
    always_comb begin
        drain_now  = sb_valid_q && !beat_acc &&
                     !(state_q != S_IDLE && sb_addr_q[ADDR_WIDTH-1:OFF_W] == rf_index_q);
        st_ready   = !sb_valid_q || drain_now;
        st_acc     = st_req && st_ready;
        sb_valid_d = st_acc || (sb_valid_q && !drain_now);
        sb_addr_d  = st_acc ? st_addr  : sb_addr_q;
        sb_data_d  = st_acc ? st_wdata : sb_data_q;
        sb_be_d    = st_acc ? st_be    : sb_be_q;

        wr_en   = beat_acc || drain_now;
        wr_addr = beat_acc ? {rf_index_q, beat_cnt_q} : sb_addr_q;
        wr_data = beat_acc ? rf_data : sb_data_q;
        wr_be   = beat_acc ? {BE_W{1'b1}} : sb_be_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Line read; bypass overlays this cycle's write, then the store still buffered afterwards
    assign rd_idx = rd_addr[ADDR_WIDTH-1:OFF_W];

    always_comb begin
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            line_w[w] = mem[{rd_idx, OFF_W'(w)}];
        end
        if (ENABLE_BYPASS) begin
            if (wr_en && wr_addr[ADDR_WIDTH-1:OFF_W] == rd_idx) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (wr_be[b]) line_w[wr_addr[OFF_W-1:0]][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
            if (sb_valid_d && sb_addr_d[ADDR_WIDTH-1:OFF_W] == rd_idx) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (sb_be_d[b]) line_w[sb_addr_d[OFF_W-1:0]][b*8 +: 8] = sb_data_d[b*8 +: 8];
                end
            end
        end
        line_flat = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            line_flat[w*DATA_WIDTH +: DATA_WIDTH] = line_w[w];
        end
        rd_data_d = line_w[rd_addr[OFF_W-1:0]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            rf_index_q <= '0;
            sb_valid_q <= 1'b0;
            sb_addr_q  <= '0;
            sb_data_q  <= '0;
            sb_be_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_line_q  <= '0;
            rf_ready_q <= 1'b0;
            rf_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rf_index_q <= rf_index_d;
            sb_valid_q <= sb_valid_d;
            sb_addr_q  <= sb_addr_d;
            sb_data_q  <= sb_data_d;
            sb_be_q    <= sb_be_d;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_data_d;
                rd_line_q <= line_flat;
            end
            rf_ready_q <= (state_d == S_FILL);
            rf_done_q  <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE) || sb_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_line  = rd_line_q;
    assign rf_ready = rf_ready_q;
    assign rf_done  = rf_done_q;
    assign busy     = busy_q;

endmodule
